// File: rtl/ex_mem_pkg.sv
// Shared definitions for the expansion-weight memory sequencer.
package ex_mem_pkg;

  localparam int unsigned HEIGHT_EX = 938;
  localparam int unsigned IDX_W     = 10;
  localparam int unsigned CNT_W     = 10;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRead,
    StDrain
  } ex_state_e;

endpackage

// File: rtl/ex_row_counter.sv
// Loadable row index / remaining-count pair shared by the LOAD and READ paths.
module ex_row_counter #(
  parameter int unsigned IdxW = 10,
  parameter int unsigned CntW = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [IdxW-1:0] base_i,
  input  logic [CntW-1:0] count_i,
  input  logic            step_i,
  output logic [IdxW-1:0] idx_o,
  output logic            last_o
);

  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] rem_q, rem_d;

  assign idx_o  = idx_q;
  assign last_o = (rem_q == CntW'(1));

  // Next index/count: load wins; the index is not advanced past the final row
  // so it always stays inside the checked range and holds the last row used.
  always_comb begin
    idx_d = idx_q;
    rem_d = rem_q;
    if (load_i) begin
      idx_d = base_i;
      rem_d = count_i;
    end else if (step_i) begin
      rem_d = rem_q - CntW'(1);
      if (!last_o) begin
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
      rem_q <= '0;
    end else begin
      idx_q <= idx_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/ex_weight_mem_ctrl.sv
// Command sequencer for the bneck 1x1 expansion-weight memory: LOAD streams
// loader rows into consecutive rows, READ returns one row per consumer request.
module ex_weight_mem_ctrl
  import ex_mem_pkg::*;
#(
  parameter int unsigned Height = HEIGHT_EX,
  parameter int unsigned IdxW   = IDX_W,
  parameter int unsigned CntW   = CNT_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_start_i,
  input  logic            rd_start_i,
  input  logic [IdxW-1:0] cmd_base_i,
  input  logic [CntW-1:0] cmd_count_i,
  input  logic            ld_valid_i,
  output logic            ld_ready_o,
  input  logic            row_req_i,
  output logic            row_valid_o,
  output logic            row_last_o,
  output logic [IdxW-1:0] mem_index_o,
  output logic            mem_en_o,
  output logic            mem_rd_o,
  output logic            mem_wr_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int unsigned SumW = CntW + 1;

  ex_state_e state_q, state_d;
  logic      done_q, done_d;
  logic      err_q, err_d;
  logic      row_valid_q, row_valid_d;
  logic      row_last_q, row_last_d;
  logic      cnt_load, cnt_step, cnt_last;
  logic      wr_issue, rd_issue;
  logic      out_of_range;
  logic [SumW-1:0] cmd_end;

  assign cmd_end      = SumW'(cmd_base_i) + SumW'(cmd_count_i);
  assign out_of_range = (cmd_end > SumW'(Height));

  ex_row_counter #(
    .IdxW(IdxW),
    .CntW(CntW)
  ) u_row_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (cnt_load),
    .base_i (cmd_base_i),
    .count_i(cmd_count_i),
    .step_i (cnt_step),
    .idx_o  (mem_index_o),
    .last_o (cnt_last)
  );

  // Next-state, command checking and memory strobe decode.
  always_comb begin
    state_d    = state_q;
    ld_ready_o = 1'b0;
    wr_issue   = 1'b0;
    rd_issue   = 1'b0;
    cnt_load   = 1'b0;
    cnt_step   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    row_last_d = 1'b0;
    case (state_q)
      StIdle: begin
        // LOAD has priority when both strobes arrive together.
        if (wr_start_i || rd_start_i) begin
          if (out_of_range) begin
            err_d = 1'b1;
          end else if (cmd_count_i == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_load = 1'b1;
            state_d  = wr_start_i ? StLoad : StRead;
          end
        end
      end
      StLoad: begin
        ld_ready_o = 1'b1;
        if (ld_valid_i) begin
          wr_issue = 1'b1;
          cnt_step = 1'b1;
          if (cnt_last) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRead: begin
        if (row_req_i) begin
          rd_issue   = 1'b1;
          cnt_step   = 1'b1;
          row_last_d = cnt_last;
          if (cnt_last) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign row_valid_d = rd_issue;

  // Control state and registered response flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      err_q       <= err_d;
      row_valid_q <= row_valid_d;
      row_last_q  <= row_last_d;
    end
  end

  assign mem_wr_o    = wr_issue;
  assign mem_rd_o    = rd_issue;
  assign mem_en_o    = wr_issue | rd_issue;
  assign row_valid_o = row_valid_q;
  assign row_last_o  = row_last_q;
  assign busy_o      = (state_q != StIdle);
  // READ completion coincides with the final row's data, seen during DRAIN.
  assign done_o      = done_q | (state_q == StDrain);
  assign err_o       = err_q;

endmodule

// File: tb/tb_ex_weight_mem_ctrl.sv
// Self-checking bench for ex_weight_mem_ctrl: directed scenarios followed by
// random traffic, every cycle compared against a command-level reference model.
module tb_ex_weight_mem_ctrl;

  localparam int HEIGHT = 938;
  localparam int K_NONE = 0, K_LOAD = 1, K_READ = 2, K_DRAIN = 3;

  logic       clk = 1'b0;
  logic       rst, wr_start, rd_start, ld_valid, row_req;
  logic [9:0] cmd_base, cmd_count;
  logic       ld_ready, row_valid, row_last, mem_en, mem_rd, mem_wr, busy, done, err;
  logic [9:0] mem_index;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: active command kind, current row, rows left, pending pulses.
  int m_kind, m_row, m_left;
  bit m_done_p, m_err_p, m_vld_p, m_last_p;

  always #5 clk = ~clk;

  ex_weight_mem_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_start_i (wr_start),
    .rd_start_i (rd_start),
    .cmd_base_i (cmd_base),
    .cmd_count_i(cmd_count),
    .ld_valid_i (ld_valid),
    .ld_ready_o (ld_ready),
    .row_req_i  (row_req),
    .row_valid_o(row_valid),
    .row_last_o (row_last),
    .mem_index_o(mem_index),
    .mem_en_o   (mem_en),
    .mem_rd_o   (mem_rd),
    .mem_wr_o   (mem_wr),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_kind = K_NONE; m_row = 0; m_left = 0;
    m_done_p = 0; m_err_p = 0; m_vld_p = 0; m_last_p = 0;
  endtask

  // Check all outputs mid-cycle, then advance the model across the next edge.
  task automatic tick();
    bit exp_wr, exp_rd, nd, ne, nv, nl;
    @(negedge clk);
    exp_wr = (m_kind == K_LOAD) && ld_valid;
    exp_rd = (m_kind == K_READ) && row_req;
    chk("ld_ready", 32'(ld_ready), 32'(m_kind == K_LOAD));
    chk("mem_wr", 32'(mem_wr), 32'(exp_wr));
    chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
    chk("mem_en", 32'(mem_en), 32'(exp_wr | exp_rd));
    chk("mem_index", 32'(mem_index), 32'(m_row));
    chk("busy", 32'(busy), 32'(m_kind != K_NONE));
    chk("done", 32'(done), 32'(m_done_p || m_kind == K_DRAIN));
    chk("err", 32'(err), 32'(m_err_p));
    chk("row_valid", 32'(row_valid), 32'(m_vld_p));
    chk("row_last", 32'(row_last), 32'(m_last_p));
    nd = 0; ne = 0; nv = 0; nl = 0;
    if (rst) begin
      model_reset();
    end else begin
      case (m_kind)
        K_NONE: if (wr_start || rd_start) begin
          if (int'(cmd_base) + int'(cmd_count) > HEIGHT) ne = 1;
          else if (cmd_count == 0) nd = 1;
          else begin
            m_kind = wr_start ? K_LOAD : K_READ;
            m_row  = int'(cmd_base);
            m_left = int'(cmd_count);
          end
        end
        K_LOAD: if (ld_valid) begin
          if (m_left == 1) begin nd = 1; m_kind = K_NONE; end
          else begin m_row++; m_left--; end
        end
        K_READ: if (row_req) begin
          nv = 1;
          nl = (m_left == 1);
          if (m_left == 1) m_kind = K_DRAIN;
          else begin m_row++; m_left--; end
        end
        default: m_kind = K_NONE;
      endcase
      m_done_p = nd; m_err_p = ne; m_vld_p = nv; m_last_p = nl;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 0; wr_start = 0; rd_start = 0; ld_valid = 0; row_req = 0;
    cmd_base = '0; cmd_count = '0;
  endtask

  task automatic start(input bit w, input bit r, input int base, input int cnt);
    wr_start = w; rd_start = r;
    cmd_base = 10'(base); cmd_count = 10'(cnt);
    tick();
    wr_start = 0; rd_start = 0;
  endtask

  task automatic idle(input int n);
    quiet();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    quiet();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    idle(2);

    // LOAD 5/3 with a loader gap on the second beat.
    start(1, 0, 5, 3);
    ld_valid = 1; tick();
    ld_valid = 0; tick();
    ld_valid = 1; tick(); tick();
    idle(3);

    // READ 100/4 with requests every other cycle.
    start(0, 1, 100, 4);
    for (int i = 0; i < 8; i++) begin row_req = (i % 2 == 0); tick(); end
    idle(3);

    // Bounds: one past the top is rejected, exactly to the top is accepted.
    start(0, 1, 936, 3);
    idle(2);
    start(1, 0, 935, 3);
    ld_valid = 1;
    for (int i = 0; i < 4; i++) tick();
    idle(2);

    // Empty READ, then simultaneous strobes.
    start(0, 1, 10, 0);
    idle(2);
    start(1, 1, 10, 2);
    ld_valid = 1; tick(); tick();
    idle(3);

    // rd_start while LOAD is active is ignored.
    start(1, 0, 20, 4);
    ld_valid = 1; tick();
    rd_start = 1; cmd_base = 10'd0; cmd_count = 10'd1; tick();
    rd_start = 0; tick(); tick();
    idle(3);

    // Reset after 2 of 5 READ rows, then a clean single-row READ.
    start(0, 1, 50, 5);
    row_req = 1; tick(); tick();
    rst = 1; tick();
    idle(2);
    start(0, 1, 0, 1);
    row_req = 1; tick();
    idle(3);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      wr_start = ($urandom_range(0, 7) == 0);
      rd_start = ($urandom_range(0, 7) == 0);
      cmd_base = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(925, 1023))
                                            : 10'($urandom_range(0, 1023));
      cmd_count = 10'($urandom_range(0, 10));
      ld_valid = 1'($urandom_range(0, 1));
      row_req  = 1'($urandom_range(0, 1));
      tick();
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
